// File: rtl/alu_control_unit_null.sv
// Registered decode stage for the null (non-arithmetic) instruction class: turns a
// 12-bit instruction plus the switch bank into the 55-bit ALU control word.
module alu_control_unit_null (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] instruction,
    input  logic [15:0] switches,
    output logic [54:0] control_word,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [3:0]  alu_out_select,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk
);

    typedef enum logic [3:0] {
        OP_UJMP = 4'b0000,
        OP_LDSW = 4'b0001,
        OP_DVGA = 4'b0010,
        OP_SWCL = 4'b0011
    } opcode_e;

    localparam logic [3:0] ALU_LEFT = 4'b0000;
    localparam logic [3:0] ALU_IADD = 4'b0001;

    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [1:0] LOAD_ALU  = 2'b01;
    localparam logic [1:0] LOAD_MEM  = 2'b10;
    localparam logic [1:0] LOAD_STK  = 2'b11;

    logic [3:0]  opcode;
    logic [3:0]  fieldF1;
    logic [3:0]  fieldF2;

    logic        pcIncD;
    logic [3:0]  aluOpD;
    logic [15:0] aAlternD;
    logic [15:0] bAlternD;
    logic [3:0]  aSelectD;
    logic [3:0]  bSelectD;
    logic        aSourceD;
    logic        bSourceD;
    logic [3:0]  outSelectD;
    logic [1:0]  loadSrcD;
    logic        storeMemD;
    logic        storeStkD;

    logic [54:0] controlWordD;
    logic [54:0] controlWordQ;

    assign opcode  = instruction[11:8];
    assign fieldF1 = instruction[7:4];
    assign fieldF2 = instruction[3:0];

    // Memory/stack group encodes opcode bits as {1, write, stack, offset}.
    always_comb begin
        pcIncD     = 1'b1;
        aluOpD     = ALU_LEFT;
        aAlternD   = 16'h0000;
        bAlternD   = 16'h0000;
        aSelectD   = 4'h0;
        bSelectD   = 4'h0;
        aSourceD   = 1'b0;
        bSourceD   = 1'b0;
        outSelectD = 4'h0;
        loadSrcD   = LOAD_NONE;
        storeMemD  = 1'b0;
        storeStkD  = 1'b0;

        if (opcode[3]) begin
            aSelectD = fieldF1;
            bSelectD = fieldF2;
            aluOpD   = opcode[0] ? ALU_IADD : ALU_LEFT;
            if (opcode[2]) begin
                outSelectD = fieldF1;
                storeMemD  = ~opcode[1];
                storeStkD  = opcode[1];
            end else begin
                outSelectD = fieldF2;
                loadSrcD   = opcode[1] ? LOAD_STK : LOAD_MEM;
            end
        end else begin
            case (opcode_e'(opcode))
                OP_LDSW: begin
                    aluOpD     = fieldF1;
                    aAlternD   = switches;
                    aSourceD   = 1'b1;
                    bSelectD   = fieldF2;
                    outSelectD = fieldF2;
                    loadSrcD   = LOAD_ALU;
                end
                default: begin
                end
            endcase
        end
    end

    assign controlWordD = {pcIncD, aluOpD, aAlternD, bAlternD, aSelectD, bSelectD,
                           aSourceD, bSourceD, outSelectD, loadSrcD, storeMemD, storeStkD};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            controlWordQ <= 55'h0;
        end else begin
            controlWordQ <= controlWordD;
        end
    end

    assign control_word              = controlWordQ;
    assign program_counter_increment = controlWordQ[54];
    assign alu_op                    = controlWordQ[53:50];
    assign alu_a_altern              = controlWordQ[49:34];
    assign alu_b_altern              = controlWordQ[33:18];
    assign alu_a_select              = controlWordQ[17:14];
    assign alu_b_select              = controlWordQ[13:10];
    assign alu_a_source              = controlWordQ[9];
    assign alu_b_source              = controlWordQ[8];
    assign alu_out_select            = controlWordQ[7:4];
    assign alu_load_src              = controlWordQ[3:2];
    assign alu_store_to_mem          = controlWordQ[1];
    assign alu_store_to_stk          = controlWordQ[0];

endmodule

// File: tb/tb_alu_control_unit_null.sv
// Directed table-driven bench for alu_control_unit_null with hand-computed control fields,
// plus reset and pre-edge latency sequences.
module tb_alu_control_unit_null;

    logic        clk;
    logic        rst;
    logic [11:0] instruction;
    logic [15:0] switches;
    logic [54:0] control_word;
    logic        program_counter_increment;
    logic [3:0]  alu_op;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [3:0]  alu_out_select;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem;
    logic        alu_store_to_stk;

    int checkCount;
    int errorCount;

    typedef struct {
        logic [11:0] instr;
        logic [15:0] sw;
        logic        pcInc;
        logic [3:0]  op;
        logic [15:0] aAlt;
        logic [3:0]  aSel;
        logic [3:0]  bSel;
        logic        aSrc;
        logic [3:0]  outSel;
        logic [1:0]  load;
        logic        stMem;
        logic        stStk;
    } vec_t;

    vec_t vecs[$];

    alu_control_unit_null dut (
        .clk                       (clk),
        .rst                       (rst),
        .instruction               (instruction),
        .switches                  (switches),
        .control_word              (control_word),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_mem          (alu_store_to_mem),
        .alu_store_to_stk          (alu_store_to_stk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [11:0] instr, logic [15:0] sw, logic [3:0] op,
                                logic [15:0] aAlt, logic [3:0] aSel, logic [3:0] bSel,
                                logic aSrc, logic [3:0] outSel, logic [1:0] load,
                                logic stMem, logic stStk);
        vec_t v;
        v.instr = instr;  v.sw = sw;     v.pcInc = 1'b1; v.op = op;
        v.aAlt = aAlt;    v.aSel = aSel; v.bSel = bSel;  v.aSrc = aSrc;
        v.outSel = outSel; v.load = load; v.stMem = stMem; v.stStk = stStk;
        return v;
    endfunction

    task automatic cmp(string name, string field, logic [54:0] got, logic [54:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s.%s got %h want %h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(string name, vec_t e);
        logic [54:0] expWord;
        expWord = {e.pcInc, e.op, e.aAlt, 16'h0000, e.aSel, e.bSel, e.aSrc, 1'b0,
                   e.outSel, e.load, e.stMem, e.stStk};
        cmp(name, "word",   control_word, expWord);
        cmp(name, "pcInc",  55'(program_counter_increment), 55'(e.pcInc));
        cmp(name, "op",     55'(alu_op), 55'(e.op));
        cmp(name, "aAlt",   55'(alu_a_altern), 55'(e.aAlt));
        cmp(name, "bAlt",   55'(alu_b_altern), 55'h0);
        cmp(name, "aSel",   55'(alu_a_select), 55'(e.aSel));
        cmp(name, "bSel",   55'(alu_b_select), 55'(e.bSel));
        cmp(name, "aSrc",   55'(alu_a_source), 55'(e.aSrc));
        cmp(name, "bSrc",   55'(alu_b_source), 55'h0);
        cmp(name, "outSel", 55'(alu_out_select), 55'(e.outSel));
        cmp(name, "load",   55'(alu_load_src), 55'(e.load));
        cmp(name, "stMem",  55'(alu_store_to_mem), 55'(e.stMem));
        cmp(name, "stStk",  55'(alu_store_to_stk), 55'(e.stStk));
    endtask

    task automatic applyStimulus(logic [11:0] instr, logic [15:0] sw);
        instruction = instr;
        switches    = sw;
    endtask

    initial begin
        vec_t zeroVec;
        vec_t prev;
        vec_t ldswReset;
        checkCount = 0;
        errorCount = 0;
        zeroVec = mk(12'h000, 16'h0000, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0);
        zeroVec.pcInc = 1'b0;

        //      instr    sw        op    aAlt      aSel  bSel  aSrc  out   load   stM   stS
        vecs.push_back(mk(12'h000, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(12'h200, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(12'h300, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(12'h5AB, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(12'h105, 16'h1242, 4'h0, 16'h1242, 4'h0, 4'h5, 1'b1, 4'h5, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk(12'h1B7, 16'h1242, 4'hB, 16'h1242, 4'h0, 4'h7, 1'b1, 4'h7, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk(12'h7FF, 16'hFFFF, 4'h0, 16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(12'h1E3, 16'hABCD, 4'hE, 16'hABCD, 4'h0, 4'h3, 1'b1, 4'h3, 2'b01, 1'b0, 1'b0));
        vecs.push_back(mk(12'h801, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h1, 2'b10, 1'b0, 1'b0));
        vecs.push_back(mk(12'h901, 16'h1242, 4'h1, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h1, 2'b10, 1'b0, 1'b0));
        vecs.push_back(mk(12'hC01, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0));
        vecs.push_back(mk(12'hD01, 16'h1242, 4'h1, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0));
        vecs.push_back(mk(12'hA01, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h1, 2'b11, 1'b0, 1'b0));
        vecs.push_back(mk(12'hB01, 16'h1242, 4'h1, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h1, 2'b11, 1'b0, 1'b0));
        vecs.push_back(mk(12'hE01, 16'h1242, 4'h0, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b1));
        vecs.push_back(mk(12'hF01, 16'h1242, 4'h1, 16'h0000, 4'h0, 4'h1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b1));
        vecs.push_back(mk(12'h8A5, 16'hFFFF, 4'h0, 16'h0000, 4'hA, 4'h5, 1'b0, 4'h5, 2'b10, 1'b0, 1'b0));
        vecs.push_back(mk(12'hE3C, 16'hFFFF, 4'h0, 16'h0000, 4'h3, 4'hC, 1'b0, 4'h3, 2'b00, 1'b0, 1'b1));
        vecs.push_back(mk(12'hB7D, 16'h0000, 4'h1, 16'h0000, 4'h7, 4'hD, 1'b0, 4'hD, 2'b11, 1'b0, 1'b0));
        vecs.push_back(mk(12'hD96, 16'h0000, 4'h1, 16'h0000, 4'h9, 4'h6, 1'b0, 4'h9, 2'b00, 1'b1, 1'b0));

        rst = 1'b1;
        applyStimulus(12'h158, 16'h1242);
        #3;
        checkOutput("reset_initial", zeroVec);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", zeroVec);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ldswReset = mk(12'h158, 16'h1242, 4'h5, 16'h1242, 4'h0, 4'h8, 1'b1, 4'h8, 2'b01, 1'b0, 1'b0);
        checkOutput("reset_release_ldsw", ldswReset);

        // Each step: new inputs at the falling edge must not reach the output before the rising edge.
        prev = ldswReset;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].instr, vecs[i].sw);
            #1;
            checkOutput($sformatf("hold_%0d", i), prev);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec_%0d_%h", i, vecs[i].instr), vecs[i]);
            prev = vecs[i];
        end

        // Switches change after the edge: the registered word must keep the sampled value.
        @(negedge clk);
        applyStimulus(12'h1B7, 16'h1242);
        @(posedge clk);
        #1;
        switches = 16'h5555;
        #2;
        checkOutput("switch_after_edge", vecs[5]);

        // Mid-cycle asynchronous reset clears without a clock edge.
        @(negedge clk);
        applyStimulus(12'h158, 16'h1242);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_async_mid", zeroVec);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_release_before_edge", zeroVec);
        @(posedge clk);
        #1;
        checkOutput("reset_release_ldsw2", ldswReset);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu_control_unit_null.md
Name: alu_control_unit_null

Overview:
- Registered instruction-to-ALU control-word stage for the null (non-arithmetic) instruction class.
- Decodes a 12-bit instruction plus the 16-bit switch bank into the packed 55-bit ALU control word.
- Registers the word, then unpacks it into individual ALU/datapath control fields.
- Sits between instruction fetch and the ALU/register-file/memory/stack datapath.

Parameters:
- None. Widths are fixed: instruction 12, data 16, control word 55.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  12  [11:8] opcode, [7:4] field F1, [3:0] field F2.
- switches  input  16  switch bank value.
- control_word  output  55  registered packed control word.
- program_counter_increment  output  1  control_word[54].
- alu_op  output  4  control_word[53:50].
- alu_a_altern  output  16  control_word[49:34].
- alu_b_altern  output  16  control_word[33:18].
- alu_a_select  output  4  control_word[17:14].
- alu_b_select  output  4  control_word[13:10].
- alu_a_source  output  1  control_word[9]; 1 selects altern, 0 selects register.
- alu_b_source  output  1  control_word[8]; same encoding as alu_a_source.
- alu_out_select  output  4  control_word[7:4]; destination register.
- alu_load_src  output  2  control_word[3:2]; 00 none, 01 ALU, 10 memory, 11 stack.
- alu_store_to_mem  output  1  control_word[1].
- alu_store_to_stk  output  1  control_word[0].

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - While rst=1, control_word = 55'h0. All unpacked outputs are therefore 0, including program_counter_increment=0 (PC holds).
- Latency:
  - Combinational decode of instruction/switches is captured into control_word on each rising clk edge.
  - Outputs reflect the instruction present before that edge: latency 1 cycle, new word every cycle, no handshake.
  - Unpacked outputs are pure wiring of control_word.
- Defaults: every field not listed for an opcode is 0. Every opcode sets program_counter_increment=1.
- Noop word: pc_inc=1, all other bits 0 (load_src=00, no stores).
- Opcode decode:
  - 0000 ujmp, 0010 dvga, 0011 swcl, 0100-0111 reserved: noop word, regardless of F1/F2. Jumps, VGA and clock switching are handled outside this block.
  - 0001 ldsw:
    - alu_op=F1.
    - alu_a_altern=switches, alu_a_source=1.
    - alu_b_select=F2, alu_b_source=0.
    - alu_out_select=F2, load_src=01.
  - Memory/stack group, opcode[3]=1; opcode[2]=write, opcode[1]=stack, opcode[0]=offset:
    - Common fields: alu_a_select=F1, alu_b_select=F2, both sources 0.
    - alu_op = 0000 (LEFT) if offset=0, 0001 (IADD) if offset=1.
    - Read (write bit=0): alu_out_select=F2; load_src=10 (memory) or 11 (stack); no stores.
    - Write (write bit=1): alu_out_select=F1; load_src=00; store_to_mem=1 if memory, store_to_stk=1 if stack.
  - Opcode values: 1000 rmem, 1001 rmof, 1010 rstk, 1011 rsof, 1100 wmem, 1101 wmof, 1110 wstk, 1111 wsof.
- Reset mid-operation: the output clears immediately, asynchronously. The first edge after rst falls loads the decode of the current instruction.
- Switches are sampled only at the clock edge; they matter only for ldsw.

Test Plan:
- Reset: assert rst with instruction=12'h158 → control_word=0 immediately, with no clock edge. Release rst, one clk edge → word of the ldsw decode.
- Noops: switches=16'h1242, instruction in {12'h000, 12'h200, 12'h300, 12'h5AB}, clk → control_word=55'h40_0000_0000_0000 (only bit 54 set).
- ldsw: instruction=12'h105, clk → alu_op=0, alu_a_altern=16'h1242, a_source=1, b_source=0, b_select=5, out_select=5, load_src=01, no stores. Then 12'h1B7 → alu_op=B, b_select=7, out_select=7.
- Memory: 12'h801 → op=0, a_sel=0, out=1, load=10. 12'h901 → op=1, b_sel=1, load=10. 12'hC01 → op=0, out=0, load=00, store_mem=1. 12'hD01 → op=1, b_sel=1, store_mem=1, store_stk=0.
- Stack: 12'hA01 → load=11. 12'hB01 → op=1, load=11. 12'hE01 → op=0, out=0, load=00, store_stk=1. 12'hF01 → op=1, store_stk=1, store_mem=0.
- Latency: change instruction every cycle → each output equals the decode of the previous cycle's instruction. Packed bits must match the unpacked fields, e.g. alu_op==control_word[53:50].
